reciprocal_iter: RTL



---
 rtl/reciprocal_iter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/reciprocal_iter.sv
// reciprocal_iter: multi-cycle signed QM.N reciprocal (linear seed plus ITER Newton-Raphson steps)
module reciprocal_iter #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 10,
  parameter int ITER  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_div0
);
  localparam int IF = WIDTH + 2;
  localparam int XW = IF + 2;
  localparam int RW = 2 * XW;
  localparam int PW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(ITER + 1);
  localparam logic [XW-1:0] C48 = XW'((64'd48 << IF) / 64'd17);
  localparam logic [XW-1:0] C32 = XW'((64'd32 << IF) / 64'd17);
  localparam logic [XW-1:0] TWO = XW'(64'd1 << (IF + 1));
  localparam logic [WIDTH-1:0] MAXW = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [RW-1:0] MAXP = RW'(MAXW);

  typedef enum logic [2:0] {IDLE, NORM, SEED, MUL_A, MUL_B, DENORM, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d, data_q, data_d;
  logic             s_q, s_d, zero_q, zero_d, div0_q, div0_d, valid_q, valid_d;
  logic [PW-1:0]    p_q, p_d;
  logic [XW-1:0]    d_q, d_d, x_q, x_d, t_q, t_d;
  logic [CW-1:0]    it_q, it_d;

  logic [WIDTH:0]   ext, m;
  logic [PW-1:0]    p;
  logic [XW-1:0]    dn, ma, mb, prodf;
  logic [RW-1:0]    prod, r;
  logic [7:0]       sh;
  logic [WIDTH-1:0] rs, res;

  // One shared multiplier; operands are steered by the current phase.
  always_comb begin
    ext = {op_q[WIDTH-1], op_q};
    m = ext[WIDTH] ? -ext : ext;
    p = '0;
    for (int i = 0; i <= WIDTH; i++) p = m[i] ? PW'(i) : p;
    dn = XW'(m) << (IF - 1 - int'(p));
    ma = (state_q == SEED) ? C32 : (state_q == MUL_A) ? d_q : x_q;
    mb = (state_q == SEED) ? d_q : (state_q == MUL_A) ? x_q : TWO - t_q;
    prod = {{XW{1'b0}}, ma} * {{XW{1'b0}}, mb};
    prodf = XW'(prod >> IF);
    sh = 8'(2 * FRAC - 1 - IF) - 8'(p_q);
    r = sh[7] ? {{XW{1'b0}}, x_q} >> (-sh) : {{XW{1'b0}}, x_q} << sh;
    rs = (r > MAXP) ? MAXW : r[WIDTH-1:0];
    res = s_q ? -rs : rs;
  end

  always_comb begin
    state_d = state_q;
    op_d = op_q;
    s_d = s_q;
    zero_d = zero_q;
    p_d = p_q;
    d_d = d_q;
    x_d = x_q;
    t_d = t_q;
    it_d = it_q;
    data_d = data_q;
    div0_d = div0_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        op_d = i_valid ? i_data : op_q;
        state_d = i_valid ? NORM : IDLE;
      end
      NORM: begin
        s_d = op_q[WIDTH-1];
        zero_d = (m == '0);
        p_d = p;
        d_d = dn;
        state_d = (m == '0) ? DENORM : SEED;
      end
      SEED: begin
        x_d = C48 - prodf;
        it_d = '0;
        state_d = MUL_A;
      end
      MUL_A: begin
        t_d = prodf;
        state_d = MUL_B;
      end
      MUL_B: begin
        x_d = prodf;
        it_d = it_q + CW'(1);
        state_d = (it_q == CW'(ITER - 1)) ? DENORM : MUL_A;
      end
      DENORM: begin
        data_d = zero_q ? MAXW : res;
        div0_d = zero_q;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        valid_d = !i_ready;
        state_d = i_ready ? IDLE : DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      op_q <= '0;
      s_q <= 1'b0;
      zero_q <= 1'b0;
      p_q <= '0;
      d_q <= '0;
      x_q <= '0;
      t_q <= '0;
      it_q <= '0;
      data_q <= '0;
      div0_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      s_q <= s_d;
      zero_q <= zero_d;
      p_q <= p_d;
      d_q <= d_d;
      x_q <= x_d;
      t_q <= t_d;
      it_q <= it_d;
      data_q <= data_d;
      div0_q <= div0_d;
      valid_q <= valid_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = valid_q;
  assign o_data = data_q;
  assign o_div0 = div0_q;
endmodule
